// File: rtl/bip_program_loader_pkg.sv
// Shared state encoding and command constants for the BIP program loader.
package bip_program_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StGetHi,
      StGetLo,
      StWrite,
      StRun
   } state_e;

   localparam logic [7:0]  CMD_LOAD  = 8'h4C;
   localparam logic [7:0]  CMD_RUN   = 8'h52;
   localparam logic [15:0] HALT_WORD = 16'h0000;

endpackage

// File: rtl/bip_program_loader_if.sv
// Loader bus: UART rx/tx side, CPU control and program-memory write port.
// master = loader side, slave = surrounding system (UART, CPU, memory).
interface bip_program_loader_if #(
   parameter int unsigned NB_DATA   = 8,
   parameter int unsigned RAM_WIDTH = 16,
   parameter int unsigned NB_ADDR   = 11
);

   logic [NB_DATA-1:0]   i_rx_data;
   logic                 i_rx_done;
   logic                 i_halt;
   logic                 i_tx_done;
   logic                 o_pm_wr_en;
   logic [NB_ADDR-1:0]   o_pm_addr;
   logic [RAM_WIDTH-1:0] o_pm_data;
   logic                 o_cpu_run;
   logic                 o_busy;
   logic                 o_tx_start;
   logic [NB_DATA-1:0]   o_tx_data;

   modport master (
      input  i_rx_data, i_rx_done, i_halt, i_tx_done,
      output o_pm_wr_en, o_pm_addr, o_pm_data, o_cpu_run, o_busy, o_tx_start, o_tx_data
   );

   modport slave (
      output i_rx_data, i_rx_done, i_halt, i_tx_done,
      input  o_pm_wr_en, o_pm_addr, o_pm_data, o_cpu_run, o_busy, o_tx_start, o_tx_data
   );

endinterface

// File: rtl/loader_echo_buf.sv
// One-deep echo holding register: a request is sent when the transmitter is idle,
// otherwise held; a newer request overwrites the held byte.
module loader_echo_buf #(
   parameter int unsigned NB_DATA = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req,
   input  logic [NB_DATA-1:0] i_byte,
   input  logic               i_tx_done,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data
);

   logic               pend_q;
   logic [NB_DATA-1:0] byte_q;
   logic               start_q;
   logic [NB_DATA-1:0] data_q;
   logic               pend_d;
   logic [NB_DATA-1:0] byte_d;

   always_comb begin
      pend_d = pend_q | i_req;
      byte_d = i_req ? i_byte : byte_q;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pend_q  <= 1'b0;
         byte_q  <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
      end else begin
         byte_q <= byte_d;
         if (pend_d && i_tx_done) begin
            start_q <= 1'b1;
            data_q  <= byte_d;
            pend_q  <= 1'b0;
         end else begin
            start_q <= 1'b0;
            pend_q  <= pend_d;
         end
      end
   end

   assign o_tx_start = start_q;
   assign o_tx_data  = data_q;

endmodule

// File: rtl/bip_program_loader.sv
// UART-driven program loader: 'L' streams big-endian words into program memory,
// 'R' releases the CPU until HALT. Optional byte echo with LOADER_ECHO_EN.
module bip_program_loader
   import bip_program_loader_pkg::*;
#(
   parameter int unsigned NB_DATA   = 8,
   parameter int unsigned RAM_WIDTH = 16,
   parameter int unsigned NB_ADDR   = 11
) (
   input logic                 i_clk,
   input logic                 i_rst,
   bip_program_loader_if.master bus
);

   state_e               state_q;
   logic [NB_ADDR-1:0]   cnt_q;
   logic [NB_ADDR-1:0]   pm_addr_q;
   logic [RAM_WIDTH-1:0] pm_data_q;
   logic                 wr_en_q;
   logic                 cpu_run_q;
   logic                 busy_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pm_addr_q <= '0;
         pm_data_q <= '0;
         wr_en_q   <= 1'b0;
         cpu_run_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.i_rx_done) begin
                  if (bus.i_rx_data == CMD_LOAD) begin
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= StGetHi;
                  end else if (bus.i_rx_data == CMD_RUN) begin
                     cpu_run_q <= 1'b1;
                     state_q   <= StRun;
                  end
               end
            end
            StGetHi: begin
               if (bus.i_rx_done) begin
                  pm_data_q[RAM_WIDTH-1 -: NB_DATA] <= bus.i_rx_data;
                  state_q                          <= StGetLo;
               end
            end
            StGetLo: begin
               if (bus.i_rx_done) begin
                  pm_data_q[NB_DATA-1:0] <= bus.i_rx_data;
                  pm_addr_q              <= cnt_q;
                  wr_en_q                <= 1'b1;
                  state_q                <= StWrite;
               end
            end
            StWrite: begin
               cnt_q <= cnt_q + 1'b1;
               // Stop on HALT word or at the top address so the load never wraps.
               if (pm_data_q == HALT_WORD || cnt_q == {NB_ADDR{1'b1}}) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  state_q <= StGetHi;
               end
            end
            StRun: begin
               if (bus.i_halt) begin
                  cpu_run_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.o_pm_wr_en = wr_en_q;
   assign bus.o_pm_addr  = pm_addr_q;
   assign bus.o_pm_data  = pm_data_q;
   assign bus.o_cpu_run  = cpu_run_q;
   assign bus.o_busy     = busy_q;

`ifdef LOADER_ECHO_EN
   logic echo_req;
   assign echo_req = bus.i_rx_done && (state_q == StGetHi || state_q == StGetLo);

   loader_echo_buf #(
      .NB_DATA(NB_DATA)
   ) u_echo_buf (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (echo_req),
      .i_byte    (bus.i_rx_data),
      .i_tx_done (bus.i_tx_done),
      .o_tx_start(bus.o_tx_start),
      .o_tx_data (bus.o_tx_data)
   );
`else
   logic unused_tx_done;
   assign unused_tx_done = bus.i_tx_done;
   assign bus.o_tx_start = 1'b0;
   assign bus.o_tx_data  = '0;
`endif

endmodule

// File: doc/bip_program_loader.md
BIP_PROGRAM_LOADER -- requirements
Module: bip_program_loader

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, UART byte width.
REQ-002 SHALL have parameter RAM_WIDTH, default 16, instruction word width (2 bytes).
REQ-003 SHALL have parameter NB_ADDR, default 11, program-memory address width.
REQ-004 SHALL have port i_clk  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_rx_data  input  NB_DATA  byte from UART receiver.
REQ-007 SHALL have port i_rx_done  input  1  one-cycle pulse, i_rx_data valid.
REQ-008 SHALL have port i_halt  input  1  level, CPU decoded HALT (opcode 0).
REQ-009 SHALL have port o_pm_wr_en  output  1  one-cycle program-memory write strobe.
REQ-010 SHALL have port o_pm_addr  output  NB_ADDR  program-memory write address.
REQ-011 SHALL have port o_pm_data  output  RAM_WIDTH  instruction word to write.
REQ-012 SHALL have port o_cpu_run  output  1  high = CPU released from reset.
REQ-013 SHALL have port o_busy  output  1  high while a load is in progress.
REQ-014 SHALL have port o_tx_start  output  1  one-cycle pulse to UART transmitter (echo only).
REQ-015 SHALL have port o_tx_data  output  NB_DATA  byte to transmit.
REQ-016 SHALL have port i_tx_done  input  1  transmitter idle / byte sent.

Function
REQ-017 SHALL implement states IDLE, GET_HI, GET_LO, WRITE, RUN.
REQ-018 IDLE: byte 0x4C ('L') SHALL clear address counter to 0, go GET_HI, assert o_busy.
REQ-019 IDLE: byte 0x52 ('R') SHALL go RUN and set o_cpu_run the following cycle.
REQ-020 IDLE: any other byte SHALL be ignored.
REQ-021 GET_HI: i_rx_done SHALL latch i_rx_data into o_pm_data[15:8], go GET_LO.
REQ-022 GET_LO: i_rx_done SHALL latch i_rx_data into o_pm_data[7:0], go WRITE.
REQ-023 WRITE SHALL last exactly one cycle, with o_pm_wr_en=1 and o_pm_addr = current counter.
REQ-024 After WRITE, the counter SHALL increment by 1.
REQ-025 After WRITE, next state SHALL be IDLE (o_busy=0) if the written word was 0x0000 (HALT) or the address was 2^NB_ADDR-1; otherwise GET_HI.
REQ-026 Addresses SHALL never wrap within a load.
REQ-027 RUN: o_cpu_run SHALL stay 1 until i_halt is sampled high; then IDLE, o_cpu_run=0 next cycle.
REQ-028 RUN: received bytes SHALL be ignored.
REQ-029 o_pm_wr_en SHALL never assert outside WRITE.
REQ-030 o_cpu_run and o_busy SHALL never both be 1.
REQ-031 Write latency SHALL be one cycle from the second byte's i_rx_done to o_pm_wr_en.

Reset
REQ-032 Asserting i_rst low SHALL force IDLE immediately, at any point including mid-load or RUN.
REQ-033 Reset SHALL clear counter, o_pm_data, o_pm_addr, o_pm_wr_en, o_cpu_run, o_busy, o_tx_start, o_tx_data to 0.
REQ-034 A partially received word SHALL be discarded on reset; nothing SHALL be written.

Configuration
REQ-035 Macro LOADER_ECHO_EN, when defined, SHALL echo every byte accepted in GET_HI/GET_LO: o_tx_data=byte, o_tx_start one-cycle pulse.
REQ-036 With LOADER_ECHO_EN, the pulse SHALL be issued only when i_tx_done=1; otherwise it SHALL be held pending (one-deep) until i_tx_done=1.
REQ-037 With LOADER_ECHO_EN, a newer echo arriving while one is pending SHALL overwrite the pending byte.
REQ-038 Without LOADER_ECHO_EN, o_tx_start and o_tx_data SHALL be tied 0 and i_tx_done unused.

Structure
REQ-039 A shared package SHALL hold the state encoding and the command constants CMD_LOAD=0x4C, CMD_RUN=0x52, HALT_WORD=0x0000.
REQ-040 The echo holding register SHALL be a sub-module, loader_echo_buf, instantiated only under LOADER_ECHO_EN.

Verification
REQ-041 'L',0x08,0x05,0x00,0x00 -> writes 0x0805@0, then 0x0000@1; o_busy=0 after the second write.
REQ-042 'L',0x12 then i_rst low -> IDLE, no write; subsequent 'L',0x00,0x00 -> write 0x0000@0.
REQ-043 'R' -> o_cpu_run=1; i_halt=1 -> o_cpu_run=0 next cycle; 'R' again -> o_cpu_run=1.
REQ-044 'L' followed by 2048 non-zero words -> last write at address 0x7FF, then IDLE; no write to 0x000.
REQ-045 LOADER_ECHO_EN, i_tx_done=0 while 0xAB received -> no o_tx_start; i_tx_done=1 -> one o_tx_start with o_tx_data=0xAB.
REQ-046 Bytes 0x00, 0xFF, 'X' in IDLE -> no state change, all outputs stay 0.
